// File: rtl/sram_ctrl_pkg.sv
// Shared types for the external async SRAM arbiter: access FSM states and
// requester indices.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      END    = 2'd3
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant. When both requesters are valid, the one that was
// not granted last time wins. The last_grant flop updates on each acceptance.
module rr_arbiter_2
   import sram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       accept,
   output logic       grant
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      if (valid[0] && !valid[1])      grant = REQ0;
      else if (valid[1] && !valid[0]) grant = REQ1;
      else                            grant = ~last_grant_q;
      last_grant_d = accept ? grant : last_grant_q;
   end

   // The reset value of REQ1 makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= REQ1;
      else        last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one external async SRAM between two requesters. Each accepted request
// runs one single-word access: SETUP, WAIT_CYCLES of ACCESS strobe, then END.
module sram_arbiter
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 19,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic [ADDR_W-1:0] sram_adr,
   output logic [DATA_W-1:0] sram_dat_o,
   input  logic [DATA_W-1:0] sram_dat_i,
   output logic              sram_dat_oe,
   output logic              sram_cs_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

   generate
      if (WAIT_CYCLES < 1) begin : g_wait_chk
         $error("sram_arbiter: WAIT_CYCLES must be >= 1");
      end
   endgenerate

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] dat_o_q, dat_o_d;
   logic              dat_oe_q, dat_oe_d;
   logic              cs_n_q, cs_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              grant;
   logic              accept;
   logic              idle;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign idle   = (state_q == IDLE);
   assign accept = idle && ((grant == REQ1) ? req1_valid : req0_valid);

   rr_arbiter_2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({req1_valid, req0_valid}),
      .accept (accept),
      .grant  (grant)
   );

   assign req0_ready = idle && (grant == REQ0);
   assign req1_ready = idle && (grant == REQ1);

   assign sel_we    = (grant == REQ1) ? req1_we    : req0_we;
   assign sel_addr  = (grant == REQ1) ? req1_addr  : req0_addr;
   assign sel_wdata = (grant == REQ1) ? req1_wdata : req0_wdata;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      owner_d     = owner_q;
      adr_d       = adr_q;
      dat_o_d     = dat_o_q;
      dat_oe_d    = dat_oe_q;
      cs_n_d      = cs_n_q;
      oe_n_d      = oe_n_q;
      we_n_d      = we_n_q;
      rsp_valid_d = 2'b00;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      case (state_q)
         IDLE: begin
            // Pin values for SETUP are loaded here so they appear on the pads in SETUP.
            if (accept) begin
               state_d  = SETUP;
               owner_d  = grant;
               we_d     = sel_we;
               adr_d    = sel_addr;
               cs_n_d   = 1'b0;
               dat_oe_d = sel_we;
               if (sel_we) dat_o_d = sel_wdata;
            end
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = CNT_LOAD;
            oe_n_d  = we_q;
            we_n_d  = !we_q;
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = END;
               oe_n_d  = 1'b1;
               we_n_d  = 1'b1;
               if (!we_q) begin
                  rsp_valid_d[owner_q] = 1'b1;
                  if (owner_q == REQ0) rdata0_d = sram_dat_i;
                  else                 rdata1_d = sram_dat_i;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         END: begin
            state_d  = IDLE;
            cs_n_d   = 1'b1;
            dat_oe_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         owner_q     <= REQ0;
         adr_q       <= '0;
         dat_o_q     <= '0;
         dat_oe_q    <= 1'b0;
         cs_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         we_n_q      <= 1'b1;
         rsp_valid_q <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         owner_q     <= owner_d;
         adr_q       <= adr_d;
         dat_o_q     <= dat_o_d;
         dat_oe_q    <= dat_oe_d;
         cs_n_q      <= cs_n_d;
         oe_n_q      <= oe_n_d;
         we_n_q      <= we_n_d;
         rsp_valid_q <= rsp_valid_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign sram_adr    = adr_q;
   assign sram_dat_o  = dat_o_q;
   assign sram_dat_oe = dat_oe_q;
   assign sram_cs_n   = cs_n_q;
   assign sram_oe_n   = oe_n_q;
   assign sram_we_n   = we_n_q;
   assign rsp0_valid  = rsp_valid_q[0];
   assign rsp1_valid  = rsp_valid_q[1];
   assign rsp0_rdata  = rdata0_q;
   assign rsp1_rdata  = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: an access-schedule reference model checked every cycle,
// an async SRAM pad model, and directed scenarios with literal expectations.
module tb_sram_arbiter;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [18:0] req0_addr = '0;
   logic [15:0] req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [18:0] req1_addr = '0;
   logic [15:0] req1_wdata = '0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [15:0] rsp0_rdata, rsp1_rdata;
   logic [18:0] sram_adr;
   logic [15:0] sram_dat_o;
   logic [15:0] sram_dat_i = 16'h0BAD;
   logic        sram_dat_oe, sram_cs_n, sram_oe_n, sram_we_n;

   sram_arbiter #(.ADDR_W(19), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
      .sram_dat_oe(sram_dat_oe), .sram_cs_n(sram_cs_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pad-level SRAM: stores while WE_n is low, drives DAT while OE_n is low.
   logic [15:0] sram_mem [int];
   always @(negedge clk) begin
      if (!sram_cs_n && !sram_we_n) begin
         chk("sram_write_dat_oe", sram_dat_oe, 1'b1);
         sram_mem[int'(sram_adr)] = sram_dat_o;
      end
      if (!sram_cs_n && !sram_oe_n)
         sram_dat_i = sram_mem.exists(int'(sram_adr)) ? sram_mem[int'(sram_adr)] : 16'h0BAD;
      else
         sram_dat_i = 16'h0BAD;
   end

   // Reference model: one access occupies cycles T+1..T+W+2 after acceptance in T.
   logic [15:0] ref_mem [int];
   bit          busy = 0;
   bit          last_g = 1;
   int          t_acc = 0;
   bit          cur_we, cur_req;
   logic [18:0] cur_addr;
   logic [15:0] cur_wdata, cur_rd;
   logic [15:0] exp_rd0 = '0, exp_rd1 = '0;
   int          p;
   bit          act, strb, idle_m, g, e0, e1;
   int          acc_log[$];
   int          acc_cyc[$];
   int          rsp0_cyc[$];
   int          rsp1_cyc[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_cs_n", sram_cs_n, 1'b1);
         chk("rst_oe_n", sram_oe_n, 1'b1);
         chk("rst_we_n", sram_we_n, 1'b1);
         chk("rst_dat_oe", sram_dat_oe, 1'b0);
         chk("rst_adr", sram_adr, 19'd0);
         chk("rst_dat_o", sram_dat_o, 16'd0);
         chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b00);
         chk("rst_rdata", {rsp1_rdata, rsp0_rdata}, 32'd0);
         busy = 0; last_g = 1; exp_rd0 = '0; exp_rd1 = '0;
      end else begin
         p    = cyc - t_acc;
         act  = busy && p >= 1 && p <= W + 2;
         strb = act && p >= 2 && p <= W + 1;
         if (act && p == W + 2 && !cur_we) begin
            if (cur_req) exp_rd1 = cur_rd;
            else         exp_rd0 = cur_rd;
         end
         chk("cs_n", sram_cs_n, !act);
         chk("oe_n", sram_oe_n, !(strb && !cur_we));
         chk("we_n", sram_we_n, !(strb && cur_we));
         chk("dat_oe", sram_dat_oe, act && cur_we);
         if (act) chk("adr", sram_adr, cur_addr);
         if (act && cur_we) chk("dat_o", sram_dat_o, cur_wdata);
         chk("rsp0_valid", rsp0_valid, act && p == W + 2 && !cur_we && !cur_req);
         chk("rsp1_valid", rsp1_valid, act && p == W + 2 && !cur_we && cur_req);
         chk("rsp0_rdata", rsp0_rdata, exp_rd0);
         chk("rsp1_rdata", rsp1_rdata, exp_rd1);
         chk("bus_conflict", !sram_oe_n && sram_dat_oe, 1'b0);

         idle_m = !busy || p >= W + 3;
         if (req0_valid && !req1_valid)      g = 0;
         else if (req1_valid && !req0_valid) g = 1;
         else                                g = !last_g;
         e0 = idle_m && req0_valid && !g;
         e1 = idle_m && req1_valid && g;
         if (req0_valid) chk("req0_ready", req0_ready, e0);
         if (req1_valid) chk("req1_ready", req1_ready, e1);

         if (req0_valid && req0_ready) begin acc_log.push_back(0); acc_cyc.push_back(cyc); end
         if (req1_valid && req1_ready) begin acc_log.push_back(1); acc_cyc.push_back(cyc); end
         if (rsp0_valid) rsp0_cyc.push_back(cyc);
         if (rsp1_valid) rsp1_cyc.push_back(cyc);

         if (e0 || e1) begin
            busy = 1; t_acc = cyc; last_g = g; cur_req = g;
            cur_we    = g ? req1_we    : req0_we;
            cur_addr  = g ? req1_addr  : req0_addr;
            cur_wdata = g ? req1_wdata : req0_wdata;
            if (cur_we) ref_mem[int'(cur_addr)] = cur_wdata;
            else        cur_rd = ref_mem.exists(int'(cur_addr)) ? ref_mem[int'(cur_addr)] : 16'h0BAD;
         end
      end
   end

   // Called just after a rising edge; returns just after the edge ending the accept cycle.
   task automatic issue(input bit n, input bit we, input logic [18:0] a, input logic [15:0] d);
      bit got = 0;
      if (n) begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
      else   begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = n ? req1_ready : req0_ready;
         @(posedge clk); #1;
      end
      if (n) req1_valid = 0; else req0_valid = 0;
      if (!got) chk("issue_timeout", 1'b0, 1'b1);
   endtask

   int base, nrsp0, nrsp1;
   bit all1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // Contention from reset: order 0,1,0,1 with W+3 spacing.
      fork
         begin issue(0, 1, 19'h00100, 16'h1111); issue(0, 0, 19'h00100, 16'h0); end
         begin issue(1, 1, 19'h00200, 16'h2222); issue(1, 0, 19'h00200, 16'h0); end
      join
      repeat (6) @(posedge clk); #1;
      chk("contention_count", acc_log.size(), 4);
      if (acc_log.size() >= 4) begin
         chk("contention_order", {acc_log[0][3:0], acc_log[1][3:0], acc_log[2][3:0], acc_log[3][3:0]}, 16'h0101);
         for (int i = 1; i < 4; i++) chk("contention_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
      end
      chk("contention_rd0", rsp0_rdata, 16'h1111);
      chk("contention_rd1", rsp1_rdata, 16'h2222);

      // Single write, then read back on requester 0.
      issue(0, 1, 19'h00010, 16'hA5A5);
      repeat (5) @(posedge clk); #1;
      chk("write_mem", sram_mem.exists(32'h10) ? sram_mem[32'h10] : 16'h0BAD, 16'hA5A5);
      nrsp1 = rsp1_cyc.size();
      issue(0, 0, 19'h00010, 16'h0);
      repeat (5) @(posedge clk); #1;
      chk("read_rdata", rsp0_rdata, 16'hA5A5);
      chk("read_latency", rsp0_cyc[rsp0_cyc.size()-1] - acc_cyc[acc_cyc.size()-1], 4);
      chk("read_no_rsp1", rsp1_cyc.size(), nrsp1);

      // Requester 1 streaming alone.
      base = acc_cyc.size();
      for (int i = 0; i < 8; i++) issue(1, 1, 19'h00300 + 19'(i), 16'hC000 + 16'(i));
      repeat (6) @(posedge clk); #1;
      chk("stream_count", acc_cyc.size() - base, 8);
      all1 = 1;
      for (int i = base; i < acc_cyc.size(); i++) begin
         if (acc_log[i] != 1) all1 = 0;
         if (i > base) chk("stream_spacing", acc_cyc[i] - acc_cyc[i-1], 5);
      end
      chk("stream_only_req1", all1, 1'b1);
      chk("stream_last_mem", sram_mem.exists(32'h307) ? sram_mem[32'h307] : 16'h0BAD, 16'hC007);

      // Read-after-write at the top address.
      issue(0, 1, 19'h7FFFF, 16'h1234);
      issue(0, 0, 19'h7FFFF, 16'h0);
      repeat (5) @(posedge clk); #1;
      chk("raw_rdata", rsp0_rdata, 16'h1234);

      // Reset in the middle of a write's ACCESS phase.
      nrsp0 = rsp0_cyc.size();
      nrsp1 = rsp1_cyc.size();
      issue(0, 1, 19'h00055, 16'hBEEF);
      @(posedge clk); #2;
      rst_n = 0;
      #1;
      chk("async_rst_cs_n", sram_cs_n, 1'b1);
      chk("async_rst_we_n", sram_we_n, 1'b1);
      chk("async_rst_dat_oe", sram_dat_oe, 1'b0);
      repeat (2) @(posedge clk); #1;
      rst_n = 1;
      base = acc_log.size();
      fork
         issue(0, 1, 19'h00066, 16'h6666);
         issue(1, 1, 19'h00077, 16'h7777);
      join
      repeat (8) @(posedge clk); #1;
      chk("post_rst_first_grant", (acc_log.size() > base) ? acc_log[base] : 9, 0);
      chk("post_rst_no_rsp0", rsp0_cyc.size(), nrsp0);
      chk("post_rst_no_rsp1", rsp1_cyc.size(), nrsp1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
